// File: rtl/numberle_pkg.sv
// Shared widths, codes and entry-state encoding for the guess entry controller.
package numberle_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUMBER_W   = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CURSOR_W   = 3;
    localparam int unsigned SLOT_W     = 2;

    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT  = 4'd9;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_SUBMIT = 2'd2
    } entry_state_t;

endpackage

// File: rtl/guess_entry_ctrl_seg_scan.sv
// Time-multiplexes the 4-digit guess buffer onto the seven-segment anodes,
// leftmost digit (anode[3]) first, SCAN_DIV cycles per digit.
module seg_scan
    import numberle_pkg::*;
#(
    parameter int unsigned        SCAN_DIV = 250000,
    parameter logic [DIGIT_W-1:0] BLANK    = BLANK_CODE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUMBER_W-1:0]   number,
    input  logic [NUM_DIGITS-1:0] filled,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [DIGIT_W-1:0]    hex_out
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]  scan_cnt;
    logic [SLOT_W-1:0] scan_idx;

    // Dwell counter and digit index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + SLOT_W'(1);
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // Registered drive for the currently selected digit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode   <= '1;
            hex_out <= BLANK;
        end else begin
            anode   <= ~(4'b1000 >> scan_idx);
            hex_out <= filled[scan_idx] ? number[{scan_idx, 2'b00} +: DIGIT_W] : BLANK;
        end
    end

endmodule

// File: rtl/guess_entry_ctrl.sv
// Collects keypad digits into a 4-digit guess with cursor/delete, offers the
// completed guess to the checker, and drives the multiplexed display.
module guess_entry_ctrl
    import numberle_pkg::*;
#(
    parameter int unsigned        SCAN_DIV = 250000,
    parameter logic [DIGIT_W-1:0] BLANK    = BLANK_CODE
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DIGIT_W-1:0]  key_val,
    input  logic                key_valid,
    input  logic                btnL,
    input  logic                btnR,
    input  logic                guess_ack,
    output logic [NUMBER_W-1:0] number,
    output logic                guess_valid,
    output logic [3:0]          anode,
    output logic [3:0]          hex_out,
    output logic [15:0]         led
);

    entry_state_t          state, state_nxt;
    logic [CURSOR_W-1:0]   cursor, cursor_nxt;
    logic [NUM_DIGITS-1:0] filled, filled_nxt;
    logic [NUMBER_W-1:0]   number_nxt;
    logic                  guess_valid_nxt;
    logic                  btnl_q, btnr_q;
    logic                  del_evt, ent_evt;
    logic [SLOT_W-1:0]     wr_slot, del_slot;

    assign del_evt  = btnL & ~btnl_q;
    assign ent_evt  = btnR & ~btnr_q;
    assign wr_slot  = cursor[SLOT_W-1:0];
    assign del_slot = SLOT_W'(cursor - CURSOR_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btnl_q <= 1'b0;
            btnr_q <= 1'b0;
        end else begin
            btnl_q <= btnL;
            btnr_q <= btnR;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_ENTRY;
            cursor      <= '0;
            filled      <= '0;
            number      <= '0;
            guess_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            cursor      <= cursor_nxt;
            filled      <= filled_nxt;
            number      <= number_nxt;
            guess_valid <= guess_valid_nxt;
        end
    end

    // One action per cycle, delete over key over enter; SUBMIT only listens for ack
    always_comb begin
        state_nxt       = state;
        cursor_nxt      = cursor;
        filled_nxt      = filled;
        number_nxt      = number;
        guess_valid_nxt = guess_valid;
        unique case (state)
            ST_ENTRY, ST_FULL: begin
                if (del_evt) begin
                    if (cursor != '0) begin
                        cursor_nxt                              = cursor - CURSOR_W'(1);
                        filled_nxt[del_slot]                    = 1'b0;
                        number_nxt[{del_slot, 2'b00} +: DIGIT_W] = '0;
                        state_nxt                               = ST_ENTRY;
                    end
                end else if (key_valid) begin
                    if (state == ST_ENTRY && key_val <= MAX_DIGIT &&
                        cursor < CURSOR_W'(NUM_DIGITS)) begin
                        cursor_nxt                              = cursor + CURSOR_W'(1);
                        filled_nxt[wr_slot]                     = 1'b1;
                        number_nxt[{wr_slot, 2'b00} +: DIGIT_W] = key_val;
                        if (cursor == CURSOR_W'(NUM_DIGITS - 1)) begin
                            state_nxt = ST_FULL;
                        end
                    end
                end else if (ent_evt) begin
                    if (state == ST_FULL) begin
                        state_nxt       = ST_SUBMIT;
                        guess_valid_nxt = 1'b1;
                    end
                end
            end
            ST_SUBMIT: begin
                if (guess_ack) begin
                    state_nxt       = ST_ENTRY;
                    cursor_nxt      = '0;
                    filled_nxt      = '0;
                    number_nxt      = '0;
                    guess_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_ENTRY;
            end
        endcase
    end

    assign led = {guess_valid, 11'd0, filled};

    seg_scan #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK    (BLANK)
    ) u_seg_scan (
        .clock   (clock),
        .reset   (reset),
        .number  (number),
        .filled  (filled),
        .anode   (anode),
        .hex_out (hex_out)
    );

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Scoreboard bench for guess_entry_ctrl: entry, delete, submit handshake and display scan.
module tb_guess_entry_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  key_val;
    logic        key_valid;
    logic        btnL;
    logic        btnR;
    logic        guess_ack;
    logic [15:0] number;
    logic        guess_valid;
    logic [3:0]  anode;
    logic [3:0]  hex_out;
    logic [15:0] led;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_v;

    guess_entry_ctrl #(
        .SCAN_DIV (4),
        .BLANK    (4'hF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_val     (key_val),
        .key_valid   (key_valid),
        .btnL        (btnL),
        .btnR        (btnR),
        .guess_ack   (guess_ack),
        .number      (number),
        .guess_valid (guess_valid),
        .anode       (anode),
        .hex_out     (hex_out),
        .led         (led)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic key(input logic [3:0] v);
        key_val   = v;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic del_press;
        btnL = 1'b1;
        step();
        btnL = 1'b0;
        step();
    endtask

    task automatic ent_press;
        btnR = 1'b1;
        step();
        btnR = 1'b0;
        step();
    endtask

    task automatic test_reset;
        reset = 1'b1; key_val = '0; key_valid = 0; btnL = 0; btnR = 0; guess_ack = 0;
        #2;
        sb.push_back(16'h0000);
        sb.push_back(16'h00FF);
        sb.push_back(16'h0000);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v) begin bad++; $display("FAIL reset_number got=%h want=%h", number, exp_v); end
        exp_v = sb.pop_front(); total++;
        if ({8'h00, anode, hex_out} !== exp_v) begin bad++; $display("FAIL reset_display got=%h%h want=%h", anode, hex_out, exp_v[7:0]); end
        exp_v = sb.pop_front(); total++;
        if ({led[15:1], guess_valid} !== exp_v) begin bad++; $display("FAIL reset_led_gv got=%h/%b want=0", led, guess_valid); end
        step();
        reset = 1'b0;
        sb.push_back(16'h007F);
        step();
        exp_v = sb.pop_front(); total++;
        if ({8'h00, anode, hex_out} !== exp_v) begin bad++; $display("FAIL first_scan got=%h%h want=%h", anode, hex_out, exp_v[7:0]); end
    endtask

    task automatic test_full_submit;
        key(4'd3); key(4'd7); key(4'd1); key(4'd9);
        sb.push_back(16'h9173);
        sb.push_back(16'h000F);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v) begin bad++; $display("FAIL full_number got=%h want=%h", number, exp_v); end
        exp_v = sb.pop_front(); total++;
        if (led !== exp_v) begin bad++; $display("FAIL full_led got=%h want=%h", led, exp_v); end
        total++;
        if (guess_valid !== 1'b0) begin bad++; $display("FAIL gv_before_enter got=%b want=0", guess_valid); end
        btnR = 1'b1;
        sb.push_back(16'h800F);
        step();
        btnR = 1'b0;
        exp_v = sb.pop_front(); total++;
        if ({led[15], 11'd0, led[3:0]} !== exp_v || guess_valid !== 1'b1) begin
            bad++; $display("FAIL enter_gv got gv=%b led=%h want gv=1 led=%h", guess_valid, led, exp_v);
        end
        // keys and buttons during SUBMIT must not disturb the offered guess
        key(4'd5);
        btnL = 1'b1; key_val = 4'd2; key_valid = 1'b1;
        step();
        btnL = 1'b0; key_valid = 1'b0;
        step(); step();
        sb.push_back(16'h9173);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || guess_valid !== 1'b1) begin
            bad++; $display("FAIL submit_hold got=%h gv=%b want=%h gv=1", number, guess_valid, exp_v);
        end
        guess_ack = 1'b1;
        sb.push_back(16'h0000);
        step();
        guess_ack = 1'b0;
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || guess_valid !== 1'b0 || led !== 16'h0000) begin
            bad++; $display("FAIL ack_clear got=%h gv=%b led=%h want=%h gv=0 led=0", number, guess_valid, led, exp_v);
        end
        sb.push_back(16'h0002);
        key(4'd2);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v) begin bad++; $display("FAIL cursor_after_ack got=%h want=%h", number, exp_v); end
        del_press();
    endtask

    task automatic test_delete;
        key(4'd5); key(4'd2);
        sb.push_back(16'h0005);
        sb.push_back(16'h0001);
        del_press();
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v) begin bad++; $display("FAIL delete_number got=%h want=%h", number, exp_v); end
        exp_v = sb.pop_front(); total++;
        if (led !== exp_v) begin bad++; $display("FAIL delete_filled got=%h want=%h", led, exp_v); end
        sb.push_back(16'h0000);
        del_press(); del_press();
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || led !== 16'h0000) begin
            bad++; $display("FAIL delete_underflow got=%h led=%h want=%h led=0", number, led, exp_v);
        end
        sb.push_back(16'h0008);
        key(4'd8);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || led !== 16'h0001) begin
            bad++; $display("FAIL key_after_underflow got=%h led=%h want=%h led=0001", number, led, exp_v);
        end
        del_press();
    endtask

    task automatic test_ignored;
        key(4'd1); key(4'd2);
        sb.push_back(16'h0021);
        key(4'hB);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || led !== 16'h0003) begin
            bad++; $display("FAIL key_over_nine got=%h led=%h want=%h led=0003", number, led, exp_v);
        end
        ent_press(); step();
        total++;
        if (guess_valid !== 1'b0) begin bad++; $display("FAIL enter_incomplete got=%b want=0", guess_valid); end
        guess_ack = 1'b1;
        sb.push_back(16'h0021);
        step();
        guess_ack = 1'b0;
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v) begin bad++; $display("FAIL ack_outside_submit got=%h want=%h", number, exp_v); end
    endtask

    task automatic test_same_cycle;
        key_val = 4'd7; key_valid = 1'b1; btnL = 1'b1;
        sb.push_back(16'h0001);
        step();
        key_valid = 1'b0; btnL = 1'b0;
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || led !== 16'h0001) begin
            bad++; $display("FAIL delete_over_key got=%h led=%h want=%h led=0001", number, led, exp_v);
        end
        sb.push_back(16'h0061);
        key(4'd6);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v) begin bad++; $display("FAIL cursor_after_same_cycle got=%h want=%h", number, exp_v); end
    endtask

    task automatic test_full_keys;
        key(4'd4); key(4'd5);
        sb.push_back(16'h5461);
        key(4'd9);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || led !== 16'h000F) begin
            bad++; $display("FAIL key_in_full got=%h led=%h want=%h led=000F", number, led, exp_v);
        end
        sb.push_back(16'h0461);
        del_press();
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || led !== 16'h0007) begin
            bad++; $display("FAIL delete_in_full got=%h led=%h want=%h led=0007", number, led, exp_v);
        end
        ent_press();
        total++;
        if (guess_valid !== 1'b0) begin bad++; $display("FAIL enter_after_full_delete got=%b want=0", guess_valid); end
        key(4'd8);
        ent_press();
        sb.push_back(16'h8461);
        exp_v = sb.pop_front(); total++;
        if (number !== exp_v || guess_valid !== 1'b1) begin
            bad++; $display("FAIL resubmit got=%h gv=%b want=%h gv=1", number, guess_valid, exp_v);
        end
        // reset while the guess is offered drops it without waiting for a clock
        reset = 1'b1;
        #1;
        total++;
        if (guess_valid !== 1'b0 || number !== 16'h0000) begin
            bad++; $display("FAIL reset_in_submit got gv=%b num=%h want gv=0 num=0", guess_valid, number);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_scan;
        logic [1:0] idx;
        logic [3:0] exp_an;
        logic [3:0] exp_hex;
        step(); step(); step();
        total++;
        if ($countones(~anode) != 1) begin bad++; $display("FAIL one_anode_low got=%b want=one zero", anode); end
        reset = 1'b1;
        #1;
        total++;
        if (anode !== 4'b1111 || hex_out !== 4'hF) begin
            bad++; $display("FAIL reset_mid_scan got=%b/%h want=1111/F", anode, hex_out);
        end
        step();
        reset = 1'b0;
        key(4'd3);
        for (int n = 2; n <= 17; n++) begin
            idx     = 2'((n - 1) / 4);
            exp_an  = ~(4'b1000 >> idx);
            exp_hex = (idx == 2'd0) ? 4'd3 : 4'hF;
            sb.push_back({8'h00, exp_an, exp_hex});
            step();
            exp_v = sb.pop_front(); total++;
            if ({8'h00, anode, hex_out} !== exp_v) begin
                bad++; $display("FAIL scan_cycle%0d got=%b/%h want=%b/%h", n, anode, hex_out, exp_v[7:4], exp_v[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_submit();
        test_delete();
        test_ignored();
        test_same_cycle();
        test_full_keys();
        test_scan();
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
